// File: rtl/accel_sched.sv
// accel_sched: serializes CPU hash/encrypt/decrypt requests into single jobs on the H/E/D engines.
// Latency: request edge to start pulse is 3 cycles; engine done to op_done is 2 cycles.
// Backpressure: a full queue holds requests in per-op pending bits; a repeat edge on a pending op is dropped and flagged.
// Optional watchdog: define ACCEL_TIMEOUT_EN to abort jobs stuck in WAIT after TIMEOUT_CYCLES.
module accel_sched #(
  parameter int QDEPTH         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        H_int,
  input  logic        E_int,
  input  logic        D_int,
  input  logic [10:0] index,
  input  logic        H_done,
  input  logic        E_done,
  input  logic        D_done,
  input  logic        err_clr,
  output logic        H_start,
  output logic        E_start,
  output logic        D_start,
  output logic [10:0] start_index,
  output logic        abort,
  output logic        op_done,
  output logic        busy,
  output logic        q_full,
  output logic        err_timeout,
  output logic        err_spurious,
  output logic        err_overflow
);

  localparam int            AW   = $clog2(QDEPTH);
  localparam logic [AW:0]   QD   = (AW+1)'(QDEPTH);
  localparam logic [1:0]    OP_H = 2'b01;
  localparam logic [1:0]    OP_E = 2'b10;
  localparam logic [1:0]    OP_D = 2'b11;

  // Reject depths that break the pointer arithmetic and limits the 13-bit watchdog cannot reach.
  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191)
  begin : g_bad_param
    $error("accel_sched: illegal QDEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [1:0]  act_op;

  // Bit order in all 3-bit vectors is {D, E, H}; H is bit 0 and wins arbitration.
  logic [2:0]  req_q;
  logic [2:0]  pend;
  logic [10:0] pend_idx [3];
  logic [2:0]  rise;
  logic [2:0]  cand;
  logic [2:0]  overflow_ev;
  logic [2:0]  done_vec;
  logic [2:0]  act_oh;

  logic [12:0] q_mem [QDEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [12:0] head;
  logic        q_empty;
  logic        q_full_i;
  logic        pop;
  logic        push;
  logic        push_ok;
  logic [2:0]  push_sel;
  logic [1:0]  push_op;
  logic [10:0] push_idx;
  logic        act_done;
  logic        spur_ev;
  logic        timeout_hit;

  assign rise        = {D_int, E_int, H_int} & ~req_q;
  assign cand        = pend | rise;
  assign overflow_ev = pend & rise;
  assign done_vec    = {D_done, E_done, H_done};
  assign act_oh      = {act_op == OP_D, act_op == OP_E, act_op == OP_H};
  assign act_done    = |(done_vec & act_oh);

  assign count    = wr_ptr - rd_ptr;
  assign q_empty  = (count == '0);
  assign q_full_i = (count == QD);
  assign head     = q_mem[rd_ptr[AW-1:0]];

  // Hold off the pop in the op_done cycle so the CPU sees a gap between jobs.
  assign pop     = (state == S_IDLE) && !q_empty && !op_done;
  assign push_ok = (|cand) && (!q_full_i || pop);
  assign push    = |push_sel;

  assign spur_ev = ((state == S_IDLE) && (|done_vec)) ||
                   ((state == S_WAIT) && (|(done_vec & ~act_oh)));

  assign busy   = (state != S_IDLE) || !q_empty || (|pend);
  assign q_full = q_full_i;

  // Pick the highest-priority request; a fresh edge bypasses the pending bit and uses the live index.
  always_comb begin
    push_sel = 3'b000;
    push_op  = OP_H;
    push_idx = index;
    if (push_ok) begin
      if (cand[0]) begin
        push_sel = 3'b001;
        push_op  = OP_H;
        push_idx = pend[0] ? pend_idx[0] : index;
      end else if (cand[1]) begin
        push_sel = 3'b010;
        push_op  = OP_E;
        push_idx = pend[1] ? pend_idx[1] : index;
      end else begin
        push_sel = 3'b100;
        push_op  = OP_D;
        push_idx = pend[2] ? pend_idx[2] : index;
      end
    end
  end

  // Edge-detect flops and pending bits; a pending op keeps its first index, later edges are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 3'b000;
      pend  <= 3'b000;
      for (int i = 0; i < 3; i++) pend_idx[i] <= '0;
    end else begin
      req_q <= {D_int, E_int, H_int};
      for (int i = 0; i < 3; i++) begin
        if (push_sel[i]) begin
          pend[i] <= 1'b0;
        end else if (rise[i] && !pend[i]) begin
          pend[i]     <= 1'b1;
          pend_idx[i] <= index;
        end
      end
    end
  end

  // Queue storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr[AW-1:0]] <= {push_op, push_idx};
  end

  // Queue pointers, one extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef ACCEL_TIMEOUT_EN
  localparam logic [12:0] TO = 13'(TIMEOUT_CYCLES);
  logic [12:0] wdog;
  logic [12:0] wdog_n;
  assign wdog_n      = wdog + 13'd1;
  assign timeout_hit = (state == S_WAIT) && (wdog_n == TO);
`else
  assign timeout_hit = 1'b0;
  assign abort       = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Job FSM: pop, pulse the engine start, wait for its done, then pulse op_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      act_op      <= OP_H;
      start_index <= '0;
      H_start     <= 1'b0;
      E_start     <= 1'b0;
      D_start     <= 1'b0;
      op_done     <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
      abort       <= 1'b0;
      wdog        <= '0;
`endif
    end else begin
      H_start <= 1'b0;
      E_start <= 1'b0;
      D_start <= 1'b0;
      op_done <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
      abort   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pop) begin
            act_op      <= head[12:11];
            start_index <= head[10:0];
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          H_start <= (act_op == OP_H);
          E_start <= (act_op == OP_E);
          D_start <= (act_op == OP_D);
`ifdef ACCEL_TIMEOUT_EN
          wdog    <= '0;
`endif
          state   <= S_WAIT;
        end
        S_WAIT: begin
`ifdef ACCEL_TIMEOUT_EN
          // Timeout outranks a done arriving on the same edge.
          if (timeout_hit) begin
            abort <= 1'b1;
            state <= S_DONE;
          end else begin
            wdog <= wdog_n;
            if (act_done) state <= S_DONE;
          end
`else
          if (act_done) state <= S_DONE;
`endif
        end
        S_DONE: begin
          op_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_spurious <= 1'b0;
      err_overflow <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      err_spurious <= (err_spurious & ~err_clr) | spur_ev;
      err_overflow <= (err_overflow & ~err_clr) | (|overflow_ev);
`ifdef ACCEL_TIMEOUT_EN
      err_timeout  <= (err_timeout & ~err_clr) | timeout_hit;
`endif
    end
  end

endmodule

// File: tb/tb_accel_sched.sv
`timescale 1ns/1ps
module tb_accel_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        H_int = 1'b0, E_int = 1'b0, D_int = 1'b0;
  logic [10:0] index = '0;
  logic        H_done = 1'b0, E_done = 1'b0, D_done = 1'b0;
  logic        err_clr = 1'b0;
  logic        H_start, E_start, D_start;
  logic [10:0] start_index;
  logic        abort, op_done, busy, q_full;
  logic        err_timeout, err_spurious, err_overflow;

  always #5 clk = ~clk;

  accel_sched #(.QDEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .H_int(H_int), .E_int(E_int), .D_int(D_int), .index(index),
    .H_done(H_done), .E_done(E_done), .D_done(D_done), .err_clr(err_clr),
    .H_start(H_start), .E_start(E_start), .D_start(D_start), .start_index(start_index),
    .abort(abort), .op_done(op_done), .busy(busy), .q_full(q_full),
    .err_timeout(err_timeout), .err_spurious(err_spurious), .err_overflow(err_overflow)
  );

  logic [2:0]  start_vec;
  logic [20:0] all_out;
  assign start_vec = {D_start, E_start, H_start};
  assign all_out   = {H_start, E_start, D_start, start_index, abort, op_done, busy, q_full,
                      err_timeout, err_spurious, err_overflow};

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0, n_start = 0, n_opdone = 0, n_abort = 0, n_multi = 0;
  int last_done = -1000, min_gap = 1000;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (int'(H_start) + int'(E_start) + int'(D_start) > 1) n_multi++;
    if (H_start || E_start || D_start) begin
      n_start++;
      if (cyc - last_done < min_gap) min_gap = cyc - last_done;
    end
    if (op_done) begin
      n_opdone++;
      last_done = cyc;
    end
    if (abort) n_abort++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "tb_accel_sched stuck");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] op, input logic lvl);
    case (op)
      2'd1: H_int = lvl;
      2'd2: E_int = lvl;
      default: D_int = lvl;
    endcase
  endtask

  task automatic set_done(input logic [1:0] op, input logic lvl);
    case (op)
      2'd1: H_done = lvl;
      2'd2: E_done = lvl;
      default: D_done = lvl;
    endcase
  endtask

  task automatic req_pulse(input logic [1:0] op, input logic [10:0] ix);
    index = ix;
    set_req(op, 1'b1);
    step;
    set_req(op, 1'b0);
    step;
  endtask

  task automatic give_done(input logic [2:0] v);
    H_done = v[0];
    E_done = v[1];
    D_done = v[2];
    step;
    H_done = 1'b0;
    E_done = 1'b0;
    D_done = 1'b0;
  endtask

  task automatic wait_start(input string nm, output logic [2:0] v, output logic [10:0] ix);
    v  = 3'b000;
    ix = '0;
    for (int i = 0; i < 40; i++) begin
      step;
      if (start_vec != 3'b000) begin
        v  = start_vec;
        ix = start_index;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_wait: no start pulse within 40 cycles, required one", nm);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [10:0] idx;
    int          dly;
    logic [2:0]  exp_start;
  } vec_t;

  typedef struct {
    logic [2:0]  v;
    logic [10:0] ix;
  } job_t;

  vec_t        vt[4];
  job_t        jq[6];
  logic [2:0]  v;
  logic [10:0] ix;
  int          s0, o0;

  initial begin
    vt[0] = '{2'd1, 11'h123, 10, 3'b001};
    vt[1] = '{2'd2, 11'h7FF, 0,  3'b010};
    vt[2] = '{2'd3, 11'h000, 3,  3'b100};
    vt[3] = '{2'd2, 11'h2A5, 1,  3'b010};

    jq[0] = '{3'b010, 11'd1};
    jq[1] = '{3'b100, 11'd2};
    jq[2] = '{3'b001, 11'd3};
    jq[3] = '{3'b010, 11'd4};
    jq[4] = '{3'b010, 11'd6};
    jq[5] = '{3'b100, 11'd5};

    // Reset state.
    repeat (2) step;
    chk("reset_outputs", 32'(all_out), 32'd0);
    rst_n = 1'b1;
    repeat (2) step;
    chk("idle_outputs", 32'(all_out), 32'd0);

    // Single-job vectors: latency, one-cycle start, captured index, op_done, busy.
    for (int r = 0; r < 4; r++) begin
      o0    = n_opdone;
      index = vt[r].idx;
      set_req(vt[r].op, 1'b1);
      step;
      chk($sformatf("v%0d_busy_on_enq", r), 32'(busy), 32'd1);
      chk($sformatf("v%0d_no_early_start", r), 32'(start_vec), 32'd0);
      step;
      chk($sformatf("v%0d_no_start_pop", r), 32'(start_vec), 32'd0);
      step;
      chk($sformatf("v%0d_start", r), 32'(start_vec), 32'(vt[r].exp_start));
      chk($sformatf("v%0d_start_index", r), 32'(start_index), 32'(vt[r].idx));
      set_req(vt[r].op, 1'b0);
      index = 11'h555;
      if (vt[r].dly == 0) set_done(vt[r].op, 1'b1);
      step;
      chk($sformatf("v%0d_start_one_cycle", r), 32'(start_vec), 32'd0);
      chk($sformatf("v%0d_index_held", r), 32'(start_index), 32'(vt[r].idx));
      if (vt[r].dly == 0) begin
        set_done(vt[r].op, 1'b0);
      end else begin
        repeat (vt[r].dly - 1) step;
        set_done(vt[r].op, 1'b1);
        step;
        set_done(vt[r].op, 1'b0);
      end
      chk($sformatf("v%0d_op_done_not_yet", r), 32'(op_done), 32'd0);
      chk($sformatf("v%0d_busy_in_done", r), 32'(busy), 32'd1);
      step;
      chk($sformatf("v%0d_op_done", r), 32'(op_done), 32'd1);
      chk($sformatf("v%0d_busy_off", r), 32'(busy), 32'd0);
      step;
      chk($sformatf("v%0d_op_done_one_cycle", r), 32'(op_done), 32'd0);
      chk($sformatf("v%0d_op_done_count", r), 32'(n_opdone - o0), 32'd1);
      step;
    end

    // Three simultaneous requests: served H, E, D with the shared index.
    s0 = n_start;
    o0 = n_opdone;
    index = 11'h005;
    H_int = 1'b1; E_int = 1'b1; D_int = 1'b1;
    step;
    H_int = 1'b0; E_int = 1'b0; D_int = 1'b0;
    index = 11'h000;
    for (int i = 0; i < 3; i++) begin
      wait_start($sformatf("tri%0d", i), v, ix);
      chk($sformatf("tri%0d_op", i), 32'(v), 32'(3'b001 << i));
      chk($sformatf("tri%0d_index", i), 32'(ix), 32'h005);
      chk($sformatf("tri%0d_no_extra_start", i), 32'(n_start - s0), 32'(i));
      give_done(v);
    end
    repeat (4) step;
    chk("tri_op_done_count", 32'(n_opdone - o0), 32'd3);
    chk("tri_busy_off", 32'(busy), 32'd0);

    // Full queue, pending drain order, overflow and err_clr.
    s0 = n_start;
    index = 11'h100;
    H_int = 1'b1;
    wait_start("full_j0", v, ix);
    H_int = 1'b0;
    chk("full_j0_op", 32'(v), 32'h1);
    chk("full_j0_index", 32'(ix), 32'h100);
    req_pulse(2'd2, 11'd1);
    req_pulse(2'd3, 11'd2);
    req_pulse(2'd1, 11'd3);
    chk("q_not_full_at3", 32'(q_full), 32'd0);
    req_pulse(2'd2, 11'd4);
    chk("q_full_at4", 32'(q_full), 32'd1);
    req_pulse(2'd3, 11'd5);
    req_pulse(2'd2, 11'd6);
    chk("no_overflow_yet", 32'(err_overflow), 32'd0);
    req_pulse(2'd2, 11'd7);
    chk("err_overflow_set", 32'(err_overflow), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("err_overflow_clr", 32'(err_overflow), 32'd0);
    err_clr = 1'b1;
    E_int = 1'b1;
    index = 11'd8;
    step;
    err_clr = 1'b0;
    E_int = 1'b0;
    chk("err_overflow_wins_clr", 32'(err_overflow), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("err_overflow_clr2", 32'(err_overflow), 32'd0);
    chk("full_still_full", 32'(q_full), 32'd1);
    chk("full_only_one_start", 32'(n_start - s0), 32'd1);
    give_done(3'b001);
    for (int i = 0; i < 6; i++) begin
      wait_start($sformatf("drain%0d", i), v, ix);
      chk($sformatf("drain%0d_op", i), 32'(v), 32'(jq[i].v));
      chk($sformatf("drain%0d_index", i), 32'(ix), 32'(jq[i].ix));
      give_done(v);
    end
    repeat (4) step;
    chk("drain_busy_off", 32'(busy), 32'd0);
    chk("drain_q_not_full", 32'(q_full), 32'd0);
    chk("drain_no_spurious", 32'(err_spurious), 32'd0);

    // Spurious done from another engine during an E job, then in IDLE.
    o0 = n_opdone;
    index = 11'h0AA;
    E_int = 1'b1;
    wait_start("spur", v, ix);
    E_int = 1'b0;
    chk("spur_op", 32'(v), 32'h2);
    step;
    give_done(3'b100);
    chk("err_spurious_wait", 32'(err_spurious), 32'd1);
    repeat (5) step;
    chk("spur_job_still_waits", 32'(n_opdone - o0), 32'd0);
    chk("spur_busy", 32'(busy), 32'd1);
    give_done(3'b010);
    repeat (3) step;
    chk("spur_op_done", 32'(n_opdone - o0), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("err_spurious_clr", 32'(err_spurious), 32'd0);
    give_done(3'b001);
    chk("err_spurious_idle", 32'(err_spurious), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    step;

`ifdef ACCEL_TIMEOUT_EN
    // Watchdog: no done returned, abort then the next queued job.
    o0 = n_opdone;
    index = 11'h321;
    H_int = 1'b1;
    wait_start("to", v, ix);
    H_int = 1'b0;
    req_pulse(2'd2, 11'h322);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step;
        if (abort) seen = 1'b1;
      end
      chk("to_abort_seen", 32'(seen), 32'd1);
    end
    chk("to_err_timeout", 32'(err_timeout), 32'd1);
    wait_start("to_next", v, ix);
    chk("to_next_op", 32'(v), 32'h2);
    chk("to_next_index", 32'(ix), 32'h322);
    chk("to_op_done", 32'(n_opdone - o0), 32'd1);
    chk("to_abort_once", 32'(n_abort), 32'd1);
    give_done(v);
    repeat (4) step;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("err_timeout_clr", 32'(err_timeout), 32'd0);
`else
    chk("no_abort", 32'(n_abort), 32'd0);
    chk("no_err_timeout", 32'(err_timeout), 32'd0);
`endif

    // Reset while waiting with two jobs queued.
    index = 11'h400;
    H_int = 1'b1;
    wait_start("rst", v, ix);
    H_int = 1'b0;
    req_pulse(2'd2, 11'h401);
    req_pulse(2'd3, 11'h402);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 32'(all_out), 32'd0);
    step;
    rst_n = 1'b1;
    s0 = n_start;
    o0 = n_opdone;
    repeat (20) step;
    chk("rst_no_starts", 32'(n_start - s0), 32'd0);
    chk("rst_no_op_done", 32'(n_opdone - o0), 32'd0);
    chk("rst_outputs_idle", 32'(all_out), 32'd0);

    chk("start_onehot", 32'(n_multi), 32'd0);
    chk("min_done_to_start_gap_ge3", 32'(min_gap >= 3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_sched.md
# accel_sched

Request scheduler between the pipelined CPU and the three cryptographic engines: hash (H), encrypt (E) and decrypt (D). It turns the CPU's level-held `H_int`/`E_int`/`D_int` requests into queued, strictly serialized jobs. Each job issues a one-cycle start pulse and an index to exactly one engine and waits for that engine's done. It then returns one `op_done` pulse to the CPU stall logic. Only one engine runs at a time because the engines share the data memory port.

## Interface
Parameters:
- `QDEPTH`, 4: job queue entries, power of two, minimum 2.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in WAIT. Used only with `ACCEL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `H_int`, `E_int`, `D_int`  in  1 each  CPU request levels; a request is the 0→1 transition.
- `index`  in  11  job operand index; captured with the request.
- `H_done`, `E_done`, `D_done`  in  1 each  engine completion pulses.
- `err_clr`  in  1  clears the sticky error flags.
- `H_start`, `E_start`, `D_start`  out  1 each  one-cycle engine start pulses.
- `start_index`  out  11  index of the active job; valid while the FSM is not IDLE.
- `abort`  out  1  one-cycle pulse to all engines when a job times out.
- `op_done`  out  1  one-cycle completion pulse to the CPU.
- `busy`  out  1  high when the FSM is not IDLE or the queue is non-empty.
- `q_full`  out  1  queue holds `QDEPTH` entries.
- `err_timeout`, `err_spurious`, `err_overflow`  out  1 each  sticky error flags.

Reset value: every output resets to 0. The queue resets empty, the FSM to IDLE, and the edge-detect flops to 0.

## Operation
- **Edge detect:** registered copies of the three request levels. A rising edge sets the matching pending bit.
- **Pending drain:** pending bits move into the queue one per cycle, in priority order H > E > D.
  - A queue entry holds `{op[1:0], index}`, with op encoding H=01, E=10, D=11.
  - Each pending bit carries the index sampled on its own rising edge.
- **Full queue:** the pending bit is held until the queue has space.
  - A new rising edge on an op whose pending bit is still set is dropped and sets `err_overflow`.
- **FSM states:**
  - **IDLE:** if the queue is non-empty, pop the head, load `start_index`, and go to ISSUE.
  - **ISSUE:** pulse the start output for the active op (exactly one cycle), clear the watchdog, then go to WAIT.
  - **WAIT:**
    - The active op's done pulse moves the FSM to DONE.
    - Done pulses from the other engines are ignored and set `err_spurious`.
    - Any done pulse seen in IDLE also sets `err_spurious`.
  - **DONE:** pulse `op_done` for one cycle, then go to IDLE.
- **Ordering:** queue order is FIFO. Pointers are `log2(QDEPTH)+1` bits and wrap modulo 2·`QDEPTH`.
- **Simultaneous push and pop** on a full queue is allowed: the occupancy stays unchanged.
- **`err_clr`** clears all three sticky flags. If `err_clr` and a new error event occur in the same cycle, the error wins.
- **Reset mid-job:** the queue and pending bits are discarded, and no `op_done` or start pulse is produced.

## Timing
- **Request to start:** with an empty queue and the FSM in IDLE, a rising edge sampled at edge T is enqueued at T. The pop happens at T+1, and the start pulse is high in the cycle after T+2.
- **Done to `op_done`:** a done pulse sampled at edge D gives `op_done` high in the cycle after D+1.
- **Back-to-back jobs:** the next start pulse occurs no earlier than 3 cycles after the previous `op_done`.
- **Done in the ISSUE cycle** (sampled the same edge as the start pulse) is not accepted; the engine must assert done no earlier than the edge after its start.
- **`busy`** falls in the same cycle the FSM re-enters IDLE with an empty queue and no pending bits set.

## Configuration
- `ACCEL_TIMEOUT_EN` defined:
  - A 13-bit watchdog counts cycles in WAIT.
  - At count `TIMEOUT_CYCLES`, the scheduler pulses `abort`, sets `err_timeout`, and goes to DONE, so `op_done` is still delivered and the CPU never hangs.
  - A done pulse arriving on the abort cycle is ignored.
- Undefined: WAIT has no exit other than the done pulse, and `abort` and `err_timeout` are tied to 0.

## Test plan
- Single H request with `index`=0x123 → `H_start` high for one cycle with `start_index`=0x123; `H_done` 10 cycles later → `op_done` pulses once, then `busy`=0.
- `H_int`, `E_int` and `D_int` rise in the same cycle with `index`=0x005 → starts issue in order H, E, D, all with 0x005, each only after the prior done, giving 3 `op_done` pulses.
- 6 requests with `QDEPTH`=4 while the first job is held in WAIT → `q_full`=1; pending requests drain later; a repeated E edge while E is pending → `err_overflow`=1, then cleared by `err_clr`.
- `D_done` during an active E job → ignored, `err_spurious`=1, job still waits for `E_done`.
- With `ACCEL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no done returned → `abort` and `err_timeout` asserted, `op_done` pulses, next queued job starts.
- `rst_n` low for 1 cycle while in WAIT with 2 jobs queued → all outputs 0, no starts issued after release.
